// File: rtl/booth_r4_mul.sv
// Radix-4 Booth sequential multiplier with signed/unsigned mode and a start/busy/done handshake.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand bypasses the Booth steps and finishes in two cycles.
module booth_r4_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] z,
    output logic               busy,
    output logic               done
);
    // Operands widen by two bits so unsigned values can be recoded as positive Booth numbers.
    localparam int EW = WIDTH + 2;
    localparam int UW = WIDTH + 4;
    localparam int AW = UW + EW + 1;
    localparam int CW = $clog2(WIDTH / 2 + 2);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [UW-1:0]          x_q, x_d;
    logic [UW-1:0]          negx_q, negx_d;
    logic                   signed_q, signed_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     z_q, z_d;
    logic                   done_q, done_d;

    logic [EW-1:0]          x_ext, y_ext;
    logic [UW-1:0]          addend, sum;
    logic signed [AW-1:0]   shifted;
    logic [CW-1:0]          last_step;

    // NOTE: every combinational output gets a default first so no path leaves one unassigned (latch).
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        x_d       = x_q;
        negx_d    = negx_q;
        signed_d  = signed_q;
        cnt_d     = cnt_q;
        z_d       = z_q;
        done_d    = 1'b0;
        x_ext     = is_signed ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
        y_ext     = is_signed ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};
        addend    = '0;
        sum       = '0;
        shifted   = '0;
        last_step = signed_q ? CW'(WIDTH / 2 - 1) : CW'(WIDTH / 2);

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d      = {{(UW - EW){x_ext[EW-1]}}, x_ext};
                    negx_d   = -{{(UW - EW){x_ext[EW-1]}}, x_ext};
                    signed_d = is_signed;
                    acc_d    = {{UW{1'b0}}, y_ext, 1'b0};
                    cnt_d    = '0;
                    state_d  = RUN;
`ifdef BOOTH_ZERO_SKIP_EN
                    if (x == '0 || y == '0) begin
                        acc_d   = '0;
                        state_d = FIN;
                    end
`endif
                end
            end
            RUN: begin
                case (acc_q[2:0])
                    3'b001, 3'b010: addend = x_q;
                    3'b011:         addend = x_q << 1;
                    3'b100:         addend = negx_q << 1;
                    3'b101, 3'b110: addend = negx_q;
                    default:        addend = '0;
                endcase
                sum     = acc_q[AW-1 -: UW] + addend;
                shifted = $signed({sum, acc_q[EW:0]}) >>> 2;
                acc_d   = shifted;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == last_step) state_d = FIN;
            end
            FIN: begin
                // Unsigned runs one extra step, so the product sits two bits lower.
                z_d     = signed_q ? acc_q[3 +: 2*WIDTH] : acc_q[1 +: 2*WIDTH];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            x_q      <= '0;
            negx_q   <= '0;
            signed_q <= 1'b0;
            cnt_q    <= '0;
            z_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            negx_q   <= negx_d;
            signed_q <= signed_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    assign z    = z_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
endmodule

// File: tb/tb_booth_r4_mul.sv
// Testbench for booth_r4_mul: 16-bit and 8-bit instances against an arithmetic product model.
module tb_booth_r4_mul;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start16, sg16, busy16, done16;
    logic [15:0] x16, y16;
    logic [31:0] z16;
    logic        start8, sg8, busy8, done8;
    logic [7:0]  x8, y8;
    logic [15:0] z8;

    booth_r4_mul #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sg16),
        .x(x16), .y(y16), .z(z16), .busy(busy16), .done(done16)
    );
    booth_r4_mul #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sg8),
        .x(x8), .y(y8), .z(z8), .busy(busy8), .done(done8)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference product: exact integer multiply, truncated to 2*WIDTH bits.
    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'({48'b0, a}) * longint'({48'b0, b});
        return p[31:0];
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'({56'b0, a}) * longint'({56'b0, b});
        return p[15:0];
    endfunction

    // Edges from the accepting edge to the edge after which done is high.
    function automatic int exp_lat(input int w, input logic s);
        return s ? w / 2 + 1 : w / 2 + 2;
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'hFFFF;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic wait_done16(output int lat);
        lat = 0;
        while (done16 !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (done8 !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output logic [31:0] zr, output int lat);
        @(negedge clk);
        x16 = a; y16 = b; sg16 = s; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        wait_done16(lat);
        zr = z16;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [15:0] zr, output int lat);
        @(negedge clk);
        x8 = a; y8 = b; sg8 = s; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(lat);
        zr = z8;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (z16 !== 32'h0 || busy16 !== 1'b0 || done16 !== 1'b0) begin
            n_err++;
            $display("FAIL reset16: z=%h busy=%b done=%b, want z=0 busy=0 done=0", z16, busy16, done16);
        end
        n_cmp++;
        if (z8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_err++;
            $display("FAIL reset8: z=%h busy=%b done=%b, want z=0 busy=0 done=0", z8, busy8, done8);
        end
    endtask

    task automatic test_directed();
        logic [15:0] a_t [3] = '{16'h0003, 16'hFFFF, 16'h8000};
        logic [15:0] b_t [3] = '{16'hFFFB, 16'hFFFF, 16'h8000};
        logic        s_t [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] z_t [3] = '{32'hFFFFFFF1, 32'hFFFE0001, 32'h40000000};
        int          l_t [3] = '{9, 10, 9};
        logic [31:0] zr;
        int lat;
        for (int i = 0; i < 3; i++) begin
            op16(a_t[i], b_t[i], s_t[i], zr, lat);
            n_cmp++;
            if (zr !== z_t[i] || lat != l_t[i]) begin
                n_err++;
                $display("FAIL directed[%0d]: z=%h lat=%0d, want z=%h lat=%0d", i, zr, lat, z_t[i], l_t[i]);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done16 !== 1'b0 || busy16 !== 1'b0) begin
                n_err++;
                $display("FAIL done_pulse[%0d]: done=%b busy=%b, want done=0 busy=0", i, done16, busy16);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(negedge clk);
        x16 = 16'd7; y16 = 16'd6; sg16 = 1'b1; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        n_cmp++;
        if (busy16 !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: busy=%b, want 1", busy16);
        end
        @(posedge clk); #1;
        x16 = 16'd1; y16 = 16'd1; sg16 = 1'b0; start16 = 1'b1;
        repeat (3) @(posedge clk);
        #1 start16 = 1'b0;
        wait_done16(lat);
        lat += 4;
        n_cmp++;
        if (z16 !== 32'd42 || lat != 9) begin
            n_err++;
            $display("FAIL ignore_start: z=%h lat=%0d, want z=%h lat=9", z16, lat, 32'd42);
        end
        // Issue the next operation in the done cycle itself.
        x16 = 16'd2; y16 = 16'hFFFE; sg16 = 1'b1; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        n_cmp++;
        if (done16 !== 1'b0 || busy16 !== 1'b1 || z16 !== 32'd42) begin
            n_err++;
            $display("FAIL start_in_done: done=%b busy=%b z=%h, want done=0 busy=1 z=%h", done16, busy16, z16, 32'd42);
        end
        wait_done16(lat);
        n_cmp++;
        if (z16 !== 32'hFFFFFFFC || lat != 9) begin
            n_err++;
            $display("FAIL back_in_done: z=%h lat=%0d, want z=FFFFFFFC lat=9", z16, lat);
        end
    endtask

    task automatic test_reset_mid_op();
        int dones;
        logic [31:0] zr;
        int lat;
        @(negedge clk);
        x16 = 16'd123; y16 = 16'hFE38; sg16 = 1'b1; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (z16 !== 32'h0 || busy16 !== 1'b0 || done16 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: z=%h busy=%b done=%b, want 0/0/0", z16, busy16, done16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done16 === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL no_done_after_abort: dones=%0d, want 0", dones);
        end
        op16(16'd123, 16'hFE38, 1'b1, zr, lat);
        n_cmp++;
        if (zr !== ref16(16'd123, 16'hFE38, 1'b1) || lat != 9) begin
            n_err++;
            $display("FAIL after_reset_op: z=%h lat=%0d, want z=%h lat=9", zr, lat, ref16(16'd123, 16'hFE38, 1'b1));
        end
    endtask

    task automatic test_random16();
        logic [15:0] a, b;
        logic s;
        logic [31:0] zr;
        int lat;
        for (int i = 0; i < 200; i++) begin
            a = pick16(); b = pick16(); s = 1'($urandom);
            op16(a, b, s, zr, lat);
            n_cmp++;
            if (zr !== ref16(a, b, s) || lat != exp_lat(16, s)) begin
                n_err++;
                $display("FAIL rand16 a=%h b=%h s=%b: z=%h lat=%0d, want z=%h lat=%0d",
                         a, b, s, zr, lat, ref16(a, b, s), exp_lat(16, s));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        int          lat_q[$];
        logic [31:0] ez;
        int          el;
        logic [15:0] a, b;
        logic s;
        int lat;
        @(negedge clk);
        a = pick16(); b = pick16(); s = 1'($urandom);
        x16 = a; y16 = b; sg16 = s; start16 = 1'b1;
        exp_q.push_back(ref16(a, b, s)); lat_q.push_back(exp_lat(16, s));
        @(posedge clk); #1;
        start16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wait_done16(lat);
            ez = exp_q.pop_front(); el = lat_q.pop_front();
            n_cmp++;
            if (z16 !== ez || lat != el) begin
                n_err++;
                $display("FAIL b2b[%0d]: z=%h lat=%0d, want z=%h lat=%0d", i, z16, lat, ez, el);
            end
            if (i < 15) begin
                a = pick16(); b = pick16(); s = 1'($urandom);
                x16 = a; y16 = b; sg16 = s; start16 = 1'b1;
                exp_q.push_back(ref16(a, b, s)); lat_q.push_back(exp_lat(16, s));
                @(posedge clk); #1;
                start16 = 1'b0;
            end
        end
    endtask

    task automatic test_width8();
        logic [7:0] corners [6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF};
        logic [7:0] a, b;
        logic s;
        logic [15:0] zr;
        int lat;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    s = (m == 1);
                    op8(corners[i], corners[j], s, zr, lat);
                    n_cmp++;
                    if (zr !== ref8(corners[i], corners[j], s) || lat != exp_lat(8, s)) begin
                        n_err++;
                        $display("FAIL w8corner a=%h b=%h s=%b: z=%h lat=%0d, want z=%h lat=%0d",
                                 corners[i], corners[j], s, zr, lat, ref8(corners[i], corners[j], s), exp_lat(8, s));
                    end
                end
            end
        end
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            op8(a, b, s, zr, lat);
            n_cmp++;
            if (zr !== ref8(a, b, s) || lat != exp_lat(8, s)) begin
                n_err++;
                $display("FAIL w8rand a=%h b=%h s=%b: z=%h lat=%0d, want z=%h lat=%0d",
                         a, b, s, zr, lat, ref8(a, b, s), exp_lat(8, s));
            end
        end
    endtask

    task automatic test_zero_operand();
        logic [31:0] zr;
        int lat;
        op16(16'h0000, 16'h1234, 1'b1, zr, lat);
        n_cmp++;
        if (zr !== 32'h0 || lat != 9) begin
            n_err++;
            $display("FAIL zero_operand: z=%h lat=%0d, want z=0 lat=9", zr, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start16 = 1'b0; sg16 = 1'b0; x16 = '0; y16 = '0;
        start8  = 1'b0; sg8  = 1'b0; x8  = '0; y8  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_directed();
        test_start_while_busy();
        test_reset_mid_op();
        test_zero_operand();
        test_random16();
        test_back_to_back();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
